// File: rtl/mlp_conv_pkg.sv
// -----------------------------------------------------------------------------
// mlp_conv_pkg
// Shared definitions for the conv weight path: the weight_load_ctrl state
// encoding, the store geometry constants and the words-per-slice helper.
// -----------------------------------------------------------------------------
package mlp_conv_pkg;

   typedef enum logic [2:0] {
      WLC_IDLE      = 3'd0,
      WLC_LOAD      = 3'd1,
      WLC_WAIT_FULL = 3'd2,
      WLC_READY     = 3'd3,
      WLC_DONE      = 3'd4
   } wlc_state_t;

   // A wide filter (S >= 5) always packs into this many store words.
   localparam int unsigned WS_WORDS_WIDE = 7;
   // Narrow filters use one word per row, never more than this many rows.
   localparam int unsigned WS_MAX_ROWS   = 5;

   // Number of 32-bit store words making up one filter slice.
   // R == 0 still costs one word so a degenerate filter cannot stall the load.
   function automatic logic [2:0] ws_words(input logic [3:0] r, input logic [3:0] s);
      logic [2:0] n;
      n = 3'd1;
      if (s >= 4'd5) begin
         n = 3'(WS_WORDS_WIDE);
      end else if (r == 4'd0) begin
         n = 3'd1;
      end else if (r > 4'(WS_MAX_ROWS)) begin
         n = 3'(WS_MAX_ROWS);
      end else begin
         n = r[2:0];
      end
      return n;
   endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// weight_load_ctrl
// Meters weight words from an AXI-Stream into weight_store one filter slice at
// a time, waits for the store's FULL pulse, presents the slice to the conv
// datapath until COMPUTE_DONE, and pulses DONE after the last slice.
//
// Optional checking: define WEIGHT_LOAD_CTRL_CHECK_EN to enable the sticky ERR
// flag (TLAST placement errors, missing FULL after 2 cycles in WAIT_FULL with a
// forced return to IDLE). Without it ERR is 0, TLAST is ignored and WAIT_FULL
// waits indefinitely.
//
// Ports
//   CLK, RESETN            clock, synchronous active-low reset
//   START, PARAM_R/S/C     job start pulse and geometry (latched in IDLE)
//   S_AXIS_*               weight word stream
//   WS_WR_EN/VALID/DATA    write port of weight_store
//   WS_PARAM_R/S           latched geometry, stable for the whole job
//   WS_FULL                store FULL pulse
//   WEIGHTS_READY          current slice is valid in the store
//   COMPUTE_DONE           datapath finished with the current slice
//   BUSY, DONE, ERR        status
// -----------------------------------------------------------------------------
module weight_load_ctrl
   import mlp_conv_pkg::*;
#(
   parameter int INPUT_WIDTH = 32,
   parameter int SLICE_CNT_W = 16
) (
   input  logic                   CLK,
   input  logic                   RESETN,
   input  logic                   START,
   input  logic [3:0]             PARAM_R,
   input  logic [3:0]             PARAM_S,
   input  logic [SLICE_CNT_W-1:0] PARAM_C,
   input  logic [INPUT_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                   S_AXIS_TVALID,
   input  logic                   S_AXIS_TLAST,
   output logic                   S_AXIS_TREADY,
   output logic                   WS_WR_EN,
   output logic                   WS_WR_VALID,
   output logic [INPUT_WIDTH-1:0] WS_WR_DATA,
   output logic [3:0]             WS_PARAM_R,
   output logic [3:0]             WS_PARAM_S,
   input  logic                   WS_FULL,
   output logic                   WEIGHTS_READY,
   input  logic                   COMPUTE_DONE,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   ERR
);

   wlc_state_t             state_q, state_d;
   logic [3:0]             r_q, r_d;
   logic [3:0]             s_q, s_d;
   logic [SLICE_CNT_W-1:0] c_q, c_d;
   logic [SLICE_CNT_W-1:0] slice_cnt_q, slice_cnt_d;
   logic [2:0]             words_q, words_d;
   logic [2:0]             word_cnt_q, word_cnt_d;
   logic                   last_word_s;
   logic                   last_slice_s;

`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
   logic                   err_q, err_d;
   logic [1:0]             wait_cnt_q, wait_cnt_d;
`else
   logic                   unused_tlast_s;
   assign unused_tlast_s = S_AXIS_TLAST;
`endif

   assign last_word_s  = ((word_cnt_q + 3'd1) == words_q);
   assign last_slice_s = ((slice_cnt_q + SLICE_CNT_W'(1)) == c_q);

   // Outputs decoded from the state register; only the write strobe and data
   // pass the stream straight through so LOAD runs at one word per cycle.
   assign S_AXIS_TREADY = (state_q == WLC_LOAD);
   assign WS_WR_EN      = (state_q == WLC_LOAD);
   assign WS_WR_VALID   = S_AXIS_TVALID & S_AXIS_TREADY;
   assign WS_WR_DATA    = S_AXIS_TDATA;
   assign WS_PARAM_R    = r_q;
   assign WS_PARAM_S    = s_q;
   assign WEIGHTS_READY = (state_q == WLC_READY);
   assign BUSY          = (state_q != WLC_IDLE);
   assign DONE          = (state_q == WLC_DONE);
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
   assign ERR           = err_q;
`else
   assign ERR           = 1'b0;
`endif

   // Next-state and counter update for the load sequencer.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      s_d         = s_q;
      c_d         = c_q;
      slice_cnt_d = slice_cnt_q;
      words_d     = words_q;
      word_cnt_d  = word_cnt_q;
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
      err_d       = err_q;
      wait_cnt_d  = wait_cnt_q;
`endif
      case (state_q)
         WLC_IDLE: begin
            if (START) begin
               r_d         = PARAM_R;
               s_d         = PARAM_S;
               c_d         = PARAM_C;
               words_d     = ws_words(PARAM_R, PARAM_S);
               slice_cnt_d = '0;
               word_cnt_d  = 3'd0;
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
               err_d       = 1'b0;
`endif
               if (PARAM_C == '0) begin
                  state_d = WLC_DONE;
               end else begin
                  state_d = WLC_LOAD;
               end
            end else begin
               state_d = WLC_IDLE;
            end
         end
         WLC_LOAD: begin
            // TREADY is 1 throughout LOAD, so TVALID alone marks an accepted word.
            if (S_AXIS_TVALID) begin
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
               // TLAST must coincide exactly with the final word of the final slice.
               if (S_AXIS_TLAST != (last_word_s & last_slice_s)) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
`endif
               if (last_word_s) begin
                  word_cnt_d = 3'd0;
                  state_d    = WLC_WAIT_FULL;
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
                  wait_cnt_d = 2'd0;
`endif
               end else begin
                  word_cnt_d = word_cnt_q + 3'd1;
               end
            end else begin
               state_d = WLC_LOAD;
            end
         end
         WLC_WAIT_FULL: begin
            if (WS_FULL) begin
               state_d = WLC_READY;
            end else begin
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
               // FULL is due on the first WAIT_FULL cycle; give up after the second.
               if (wait_cnt_q == 2'd1) begin
                  err_d   = 1'b1;
                  state_d = WLC_IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 2'd1;
               end
`else
               state_d = WLC_WAIT_FULL;
`endif
            end
         end
         WLC_READY: begin
            if (COMPUTE_DONE) begin
               slice_cnt_d = slice_cnt_q + SLICE_CNT_W'(1);
               if (last_slice_s) begin
                  state_d = WLC_DONE;
               end else begin
                  state_d = WLC_LOAD;
               end
            end else begin
               state_d = WLC_READY;
            end
         end
         WLC_DONE: begin
            state_d = WLC_IDLE;
         end
         default: begin
            state_d = WLC_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q     <= WLC_IDLE;
         r_q         <= 4'd0;
         s_q         <= 4'd0;
         c_q         <= '0;
         slice_cnt_q <= '0;
         words_q     <= 3'd0;
         word_cnt_q  <= 3'd0;
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
         err_q       <= 1'b0;
         wait_cnt_q  <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         s_q         <= s_d;
         c_q         <= c_d;
         slice_cnt_q <= slice_cnt_d;
         words_q     <= words_d;
         word_cnt_q  <= word_cnt_d;
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
         err_q       <= err_d;
         wait_cnt_q  <= wait_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_load_ctrl
// Directed bench for weight_load_ctrl with a small weight_store model that
// pulses FULL one cycle after the last write of a slice. Inputs are driven
// and outputs sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_weight_load_ctrl;

   localparam int IW = 32;
   localparam int CW = 16;
`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESETN, START;
   logic [3:0]    PARAM_R, PARAM_S;
   logic [CW-1:0] PARAM_C;
   logic [IW-1:0] S_AXIS_TDATA;
   logic          S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
   logic          WS_WR_EN, WS_WR_VALID;
   logic [IW-1:0] WS_WR_DATA;
   logic [3:0]    WS_PARAM_R, WS_PARAM_S;
   logic          WS_FULL, WEIGHTS_READY, COMPUTE_DONE, BUSY, DONE, ERR;

   int n_checks = 0;
   int n_errors = 0;

   // store model state
   int   store_words = 3;
   logic suppress_full = 1'b0;
   int   store_cnt;
   logic full_q;
   int   acc_cnt = 0;

   always #5 CLK = ~CLK;

   weight_load_ctrl #(.INPUT_WIDTH(IW), .SLICE_CNT_W(CW)) dut (
      .CLK(CLK), .RESETN(RESETN), .START(START),
      .PARAM_R(PARAM_R), .PARAM_S(PARAM_S), .PARAM_C(PARAM_C),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
      .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
      .WS_WR_EN(WS_WR_EN), .WS_WR_VALID(WS_WR_VALID), .WS_WR_DATA(WS_WR_DATA),
      .WS_PARAM_R(WS_PARAM_R), .WS_PARAM_S(WS_PARAM_S), .WS_FULL(WS_FULL),
      .WEIGHTS_READY(WEIGHTS_READY), .COMPUTE_DONE(COMPUTE_DONE),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   assign WS_FULL = full_q;

   // Store model: FULL pulses the cycle after the store_words-th write.
   always @(posedge CLK) begin
      if (!RESETN) begin
         store_cnt <= 0;
         full_q    <= 1'b0;
      end else begin
         full_q <= 1'b0;
         if (WS_WR_EN && WS_WR_VALID) begin
            if (store_cnt + 1 == store_words) begin
               store_cnt <= 0;
               full_q    <= !suppress_full;
            end else begin
               store_cnt <= store_cnt + 1;
            end
         end
      end
   end

   // Count handshakes on the stream.
   always @(posedge CLK) begin
      if (RESETN && S_AXIS_TVALID && S_AXIS_TREADY) acc_cnt <= acc_cnt + 1;
   end

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [3:0] r, input logic [3:0] s, input logic [CW-1:0] c,
                            input int words);
      store_words = words;
      PARAM_R = r;
      PARAM_S = s;
      PARAM_C = c;
      START   = 1'b1;
      step();
      START   = 1'b0;
   endtask

   // Stream n back-to-back words starting in LOAD; ends in WAIT_FULL or READY.
   task automatic load_slice(input int n, input logic [31:0] base, input int last_idx,
                             input logic expect_full);
      for (int i = 0; i < n; i++) begin
         S_AXIS_TVALID = 1'b1;
         S_AXIS_TDATA  = base + 32'(i);
         S_AXIS_TLAST  = (i == last_idx);
         #1;
         check_val("tready_load", 32'(S_AXIS_TREADY), 32'd1);
         check_val("wr_valid_load", 32'(WS_WR_VALID), 32'd1);
         check_val("wr_data", WS_WR_DATA, base + 32'(i));
         step();
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      #1;
      check_val("tready_wait", 32'(S_AXIS_TREADY), 32'd0);
      check_val("wr_en_wait", 32'(WS_WR_EN), 32'd0);
      check_val("ws_full", 32'(WS_FULL), 32'(expect_full));
      check_val("wready_wait", 32'(WEIGHTS_READY), 32'd0);
      if (expect_full) begin
         step();
         check_val("wready_set", 32'(WEIGHTS_READY), 32'd1);
      end
   endtask

   // Final COMPUTE_DONE of a job: DONE for one cycle, then idle.
   task automatic finish_job();
      COMPUTE_DONE = 1'b1;
      step();
      COMPUTE_DONE = 1'b0;
      check_val("done_pulse", 32'(DONE), 32'd1);
      check_val("wready_drop", 32'(WEIGHTS_READY), 32'd0);
      step();
      check_val("done_clear", 32'(DONE), 32'd0);
      check_val("busy_idle", 32'(BUSY), 32'd0);
   endtask

   initial begin
      int acc0;
      int done_cnt;
      int tr_cnt;
      int w;
      int pat[5] = '{1, 0, 0, 1, 1};

      RESETN = 1'b0; START = 1'b0; PARAM_R = 4'd0; PARAM_S = 4'd0; PARAM_C = '0;
      S_AXIS_TDATA = 32'h1234_5678; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
      COMPUTE_DONE = 1'b0;
      step();
      step();
      // reset state
      check_val("rst_busy", 32'(BUSY), 32'd0);
      check_val("rst_tready", 32'(S_AXIS_TREADY), 32'd0);
      check_val("rst_wr_en", 32'(WS_WR_EN), 32'd0);
      check_val("rst_wr_valid", 32'(WS_WR_VALID), 32'd0);
      check_val("rst_wready", 32'(WEIGHTS_READY), 32'd0);
      check_val("rst_done", 32'(DONE), 32'd0);
      check_val("rst_err", 32'(ERR), 32'd0);
      check_val("rst_param_r", 32'(WS_PARAM_R), 32'd0);
      check_val("rst_wr_data", WS_WR_DATA, 32'h1234_5678);
      RESETN = 1'b1;
      step();

      // R=3 S=3 C=1: three words
      acc0 = acc_cnt;
      start_job(4'd3, 4'd3, 16'd1, 3);
      check_val("t1_busy", 32'(BUSY), 32'd1);
      check_val("t1_param_r", 32'(WS_PARAM_R), 32'd3);
      check_val("t1_param_s", 32'(WS_PARAM_S), 32'd3);
      load_slice(3, 32'h0102_0304, 2, 1'b1);
      finish_job();
      check_val("t1_err", 32'(ERR), 32'd0);
      check_val("t1_words", 32'(acc_cnt - acc0), 32'd3);

      // R=5 S=5 C=2: two slices of 7
      acc0 = acc_cnt;
      start_job(4'd5, 4'd5, 16'd2, 7);
      load_slice(7, 32'hA000_0000, -1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         check_val("t2_hold_wready", 32'(WEIGHTS_READY), 32'd1);
         check_val("t2_hold_tready", 32'(S_AXIS_TREADY), 32'd0);
      end
      COMPUTE_DONE = 1'b1;
      step();
      COMPUTE_DONE = 1'b0;
      check_val("t2_reload_tready", 32'(S_AXIS_TREADY), 32'd1);
      check_val("t2_reload_wready", 32'(WEIGHTS_READY), 32'd0);
      load_slice(7, 32'hB000_0000, 6, 1'b1);
      finish_job();
      check_val("t2_words", 32'(acc_cnt - acc0), 32'd14);
      check_val("t2_err", 32'(ERR), 32'd0);

      // R=0 S=1 C=1: one word
      acc0 = acc_cnt;
      start_job(4'd0, 4'd1, 16'd1, 1);
      load_slice(1, 32'h0000_0055, 0, 1'b1);
      finish_job();
      check_val("t3_words", 32'(acc_cnt - acc0), 32'd1);

      // C=0: straight to DONE, no stream traffic
      start_job(4'd3, 4'd3, 16'd0, 3);
      done_cnt = 0;
      tr_cnt   = 0;
      check_val("t4_done_first", 32'(DONE), 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (DONE) done_cnt++;
         if (S_AXIS_TREADY) tr_cnt++;
         step();
      end
      check_val("t4_done_cnt", 32'(done_cnt), 32'd1);
      check_val("t4_tready_cnt", 32'(tr_cnt), 32'd0);
      check_val("t4_busy", 32'(BUSY), 32'd0);

      // TVALID 1,0,0,1,1 with R=3 S=4
      acc0 = acc_cnt;
      start_job(4'd3, 4'd4, 16'd1, 3);
      w = 0;
      for (int k = 0; k < 5; k++) begin
         S_AXIS_TVALID = (pat[k] != 0);
         S_AXIS_TDATA  = 32'h0000_00C0 + 32'(w);
         S_AXIS_TLAST  = (pat[k] != 0) && (w == 2);
         #1;
         check_val("t5_wr_valid", 32'(WS_WR_VALID), 32'(pat[k]));
         check_val("t5_tready", 32'(S_AXIS_TREADY), 32'd1);
         if (pat[k] != 0) w++;
         step();
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      #1;
      check_val("t5_tready_off", 32'(S_AXIS_TREADY), 32'd0);
      check_val("t5_full", 32'(WS_FULL), 32'd1);
      step();
      check_val("t5_wready", 32'(WEIGHTS_READY), 32'd1);
      finish_job();
      check_val("t5_words", 32'(acc_cnt - acc0), 32'd3);

      // early TLAST on word 2 of 3
      start_job(4'd3, 4'd3, 16'd1, 3);
      load_slice(3, 32'h0000_00E0, 1, 1'b1);
      check_val("t6_err", 32'(ERR), 32'(CHK_EN));
      finish_job();
      check_val("t6_err_sticky", 32'(ERR), 32'(CHK_EN));

`ifdef WEIGHT_LOAD_CTRL_CHECK_EN
      // store never signals FULL: timeout back to IDLE
      suppress_full = 1'b1;
      start_job(4'd3, 4'd3, 16'd1, 3);
      check_val("t7_err_clr", 32'(ERR), 32'd0);
      load_slice(3, 32'h0000_00F0, 2, 1'b0);
      check_val("t7_busy0", 32'(BUSY), 32'd1);
      step();
      check_val("t7_busy1", 32'(BUSY), 32'd1);
      check_val("t7_err1", 32'(ERR), 32'd0);
      step();
      check_val("t7_idle", 32'(BUSY), 32'd0);
      check_val("t7_err", 32'(ERR), 32'd1);
      check_val("t7_no_done", 32'(DONE), 32'd0);
      suppress_full = 1'b0;
      start_job(4'd3, 4'd3, 16'd0, 3);
      check_val("t7_start_clr", 32'(ERR), 32'd0);
      step();
`endif

      // reset in the middle of LOAD
      start_job(4'd5, 4'd5, 16'd2, 7);
      for (int i = 0; i < 3; i++) begin
         S_AXIS_TVALID = 1'b1;
         S_AXIS_TDATA  = 32'h0000_0D00 + 32'(i);
         S_AXIS_TLAST  = 1'b0;
         step();
      end
      RESETN = 1'b0;
      step();
      #1;
      check_val("t8_busy", 32'(BUSY), 32'd0);
      check_val("t8_tready", 32'(S_AXIS_TREADY), 32'd0);
      check_val("t8_wr_en", 32'(WS_WR_EN), 32'd0);
      check_val("t8_wr_valid", 32'(WS_WR_VALID), 32'd0);
      check_val("t8_wready", 32'(WEIGHTS_READY), 32'd0);
      check_val("t8_done", 32'(DONE), 32'd0);
      check_val("t8_err", 32'(ERR), 32'd0);
      check_val("t8_param_r", 32'(WS_PARAM_R), 32'd0);
      check_val("t8_param_s", 32'(WS_PARAM_S), 32'd0);
      RESETN = 1'b1;
      S_AXIS_TVALID = 1'b0;
      step();
      // a fresh job must not see the abandoned partial slice
      start_job(4'd3, 4'd3, 16'd1, 3);
      load_slice(3, 32'h0102_0304, 2, 1'b1);
      finish_job();
      check_val("t8_err_after", 32'(ERR), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
